sipp_rf_wb_arbiter: RTL and testbench

Shares the single write port of the SIPP register file between two writeback requesters: A (ALU result) and B (load return). Each requester has a valid/ready channel into a private 2-entry FIFO. A round-robin arbiter drains one entry per cycle onto registered w_wr/w_addr/w_data outputs. A per-register busy vector lets issue logic stall on pending writes.

---
 rtl/sipp_rf_wb_arbiter_if.sv | 31 +++
 rtl/sipp_rf_wb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sipp_rf_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sipp_rf_wb_arbiter_if.sv
// Writeback bus of the SIPP register-file arbiter: two requester channels in,
// one register-file write port plus busy/idle status out.
interface sipp_rf_wb_arbiter_if #(
    parameter int N_ELEMENTS = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                  a_valid;
    logic                  a_ready;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  b_valid;
    logic                  b_ready;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [N_ELEMENTS-1:0] busy;
    logic                  idle;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, w_wr, w_addr, w_data, busy, idle
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, w_wr, w_addr, w_data, busy, idle
    );
endinterface

// File: rtl/sipp_rf_wb_arbiter.sv
// Round-robin writeback arbiter for the SIPP register file: two 2-entry FIFOs
// drained onto a registered write port. Optional macro SIPP_WB_ZERO_REG_EN hardwires register 0.
module sipp_rf_wb_arbiter #(
    parameter int N_ELEMENTS = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    sipp_rf_wb_arbiter_if.slave bus
);
    localparam int CH = 2;

    // Records which channel won the most recent contended arbitration.
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e last_r;
    grant_e last_s;

    logic [ADDR_WIDTH-1:0] q_addr_r [CH][2];
    logic [DATA_WIDTH-1:0] q_data_r [CH][2];
    logic [1:0]            count_r  [CH];
    logic [CH-1:0]         rd_ptr_r;
    logic [CH-1:0]         wr_ptr_r;

    logic [ADDR_WIDTH-1:0] in_addr_s [CH];
    logic [DATA_WIDTH-1:0] in_data_s [CH];
    logic [CH-1:0]         in_valid_s;
    logic [CH-1:0]         ready_s;
    logic [CH-1:0]         push_s;
    logic [CH-1:0]         pop_s;
    logic [CH-1:0]         head_valid_s;
    logic                  sel_s;
    logic [ADDR_WIDTH-1:0] head_addr_s;
    logic [DATA_WIDTH-1:0] head_data_s;

    logic                  w_wr_r;
    logic [ADDR_WIDTH-1:0] w_addr_r;
    logic [DATA_WIDTH-1:0] w_data_r;
    logic [N_ELEMENTS-1:0] busy_s;

    // Channel-indexed views of the requester inputs and handshake qualification.
    always_comb begin
        in_valid_s   = {bus.b_valid, bus.a_valid};
        in_addr_s[0] = bus.a_addr;
        in_addr_s[1] = bus.b_addr;
        in_data_s[0] = bus.a_data;
        in_data_s[1] = bus.b_data;
        ready_s      = '0;
        push_s       = '0;
        head_valid_s = '0;
        for (int ch = 0; ch < CH; ch++) begin
            ready_s[ch]      = !rst && (count_r[ch] != 2'd2);
            head_valid_s[ch] = (count_r[ch] != 2'd0);
`ifdef SIPP_WB_ZERO_REG_EN
            // Writes to the hardwired zero register complete the handshake but are dropped.
            push_s[ch] = in_valid_s[ch] && ready_s[ch] && (in_addr_s[ch] != {ADDR_WIDTH{1'b0}});
`else
            push_s[ch] = in_valid_s[ch] && ready_s[ch];
`endif
        end
    end

    // Arbitration over FIFO heads; the pointer toggles only when both heads compete.
    always_comb begin
        pop_s  = 2'b00;
        sel_s  = 1'b0;
        last_s = last_r;
        case (head_valid_s)
            2'b01: begin
                pop_s = 2'b01;
                sel_s = 1'b0;
            end
            2'b10: begin
                pop_s = 2'b10;
                sel_s = 1'b1;
            end
            2'b11: begin
                if (last_r == GRANT_B) begin
                    pop_s  = 2'b01;
                    sel_s  = 1'b0;
                    last_s = GRANT_A;
                end else begin
                    pop_s  = 2'b10;
                    sel_s  = 1'b1;
                    last_s = GRANT_B;
                end
            end
            default: begin
                pop_s = 2'b00;
                sel_s = 1'b0;
            end
        endcase
        head_addr_s = q_addr_r[sel_s][rd_ptr_r[sel_s]];
        head_data_s = q_data_r[sel_s][rd_ptr_r[sel_s]];
    end

    // Round-robin pointer; reset leaves B as last winner so A is favoured first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= GRANT_B;
        end else begin
            last_r <= last_s;
        end
    end

    // FIFO occupancy and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            for (int ch = 0; ch < CH; ch++) begin
                count_r[ch] <= 2'd0;
            end
        end else begin
            rd_ptr_r <= rd_ptr_r ^ pop_s;
            wr_ptr_r <= wr_ptr_r ^ push_s;
            for (int ch = 0; ch < CH; ch++) begin
                count_r[ch] <= count_r[ch] + {1'b0, push_s[ch]} - {1'b0, pop_s[ch]};
            end
        end
    end

    // FIFO storage; contents are only meaningful under the occupancy count.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < CH; ch++) begin
            if (push_s[ch]) begin
                q_addr_r[ch][wr_ptr_r[ch]] <= in_addr_s[ch];
                q_data_r[ch][wr_ptr_r[ch]] <= in_data_s[ch];
            end
        end
    end

    // Registered write port; address/data hold while no write is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_wr_r   <= 1'b0;
            w_addr_r <= '0;
            w_data_r <= '0;
        end else begin
            w_wr_r <= |pop_s;
            if (|pop_s) begin
                w_addr_r <= head_addr_s;
                w_data_r <= head_data_s;
            end
        end
    end

    // Pending-write scoreboard over every occupied FIFO slot plus the output stage.
    always_comb begin
        busy_s = '0;
        for (int ch = 0; ch < CH; ch++) begin
            for (int j = 0; j < 2; j++) begin
                if ((count_r[ch] == 2'd2) ||
                    ((count_r[ch] == 2'd1) && (rd_ptr_r[ch] == 1'(j)))) begin
                    busy_s[q_addr_r[ch][j]] = 1'b1;
                end else begin
                    busy_s = busy_s;
                end
            end
        end
        if (w_wr_r) begin
            busy_s[w_addr_r] = 1'b1;
        end else begin
            busy_s = busy_s;
        end
    end

    assign bus.a_ready = ready_s[0];
    assign bus.b_ready = ready_s[1];
    assign bus.w_wr    = w_wr_r;
    assign bus.w_addr  = w_addr_r;
    assign bus.w_data  = w_data_r;
    assign bus.busy    = busy_s;
    assign bus.idle    = (count_r[0] == 2'd0) && (count_r[1] == 2'd0) && !w_wr_r;
endmodule

// File: tb/tb_sipp_rf_wb_arbiter.sv
// Self-checking bench for sipp_rf_wb_arbiter: directed scenarios plus randomized
// traffic scored against a queue-based model of pending writes.
module tb_sipp_rf_wb_arbiter;
    localparam int NE = 16;
    localparam int AW = 4;
    localparam int DW = 16;
`ifdef SIPP_WB_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    typedef logic [AW+DW-1:0] ent_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    sipp_rf_wb_arbiter_if #(.N_ELEMENTS(NE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sipp_rf_wb_arbiter #(.N_ELEMENTS(NE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.a_valid = 1'b0;
        bus.a_addr  = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_addr  = '0;
        bus.b_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        quiet_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        quiet_inputs();
        tick();
        checks++; if (bus.w_wr !== 1'b0) begin errors++; $display("FAIL reset_w_wr got %b want 0", bus.w_wr); end
        checks++; if (bus.w_addr !== 4'h0) begin errors++; $display("FAIL reset_w_addr got %h want 0", bus.w_addr); end
        checks++; if (bus.w_data !== 16'h0000) begin errors++; $display("FAIL reset_w_data got %h want 0", bus.w_data); end
        checks++; if (bus.busy !== 16'h0000) begin errors++; $display("FAIL reset_busy got %h want 0", bus.busy); end
        checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", bus.idle); end
        checks++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {bus.a_ready, bus.b_ready}); end
        rst = 1'b0;
        #1;
        checks++; if ({bus.a_ready, bus.b_ready} !== 2'b11) begin errors++; $display("FAIL reset_release_ready got %b want 11", {bus.a_ready, bus.b_ready}); end
    endtask

    task automatic test_single();
        do_reset();
        bus.a_valid = 1'b1; bus.a_addr = 4'd3; bus.a_data = 16'h1234;
        #1;
        checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", bus.a_ready); end
        tick();
        bus.a_valid = 1'b0;
        checks++; if (bus.w_wr !== 1'b0) begin errors++; $display("FAIL single_c1_w_wr got %b want 0", bus.w_wr); end
        checks++; if (bus.busy !== 16'h0008) begin errors++; $display("FAIL single_c1_busy got %h want 0008", bus.busy); end
        checks++; if (bus.idle !== 1'b0) begin errors++; $display("FAIL single_c1_idle got %b want 0", bus.idle); end
        tick();
        checks++; if ({bus.w_wr, bus.w_addr, bus.w_data} !== {1'b1, 4'd3, 16'h1234}) begin
            errors++; $display("FAIL single_c2_write got wr=%b addr=%h data=%h want 1/3/1234", bus.w_wr, bus.w_addr, bus.w_data); end
        checks++; if (bus.busy !== 16'h0008) begin errors++; $display("FAIL single_c2_busy got %h want 0008", bus.busy); end
        tick();
        checks++; if (bus.w_wr !== 1'b0) begin errors++; $display("FAIL single_c3_w_wr got %b want 0", bus.w_wr); end
        checks++; if (bus.busy !== 16'h0000) begin errors++; $display("FAIL single_c3_busy got %h want 0", bus.busy); end
        checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL single_c3_idle got %b want 1", bus.idle); end
        checks++; if ({bus.w_addr, bus.w_data} !== {4'd3, 16'h1234}) begin
            errors++; $display("FAIL single_hold got addr=%h data=%h want 3/1234", bus.w_addr, bus.w_data); end
    endtask

    task automatic test_contention();
        logic [AW-1:0] a_seq [3];
        logic [AW-1:0] b_seq [3];
        logic [AW-1:0] want  [6];
        logic [AW-1:0] got_addr [$];
        int            got_cyc  [$];
        int            ia = 0;
        int            ib = 0;
        bit            acc_a;
        bit            acc_b;
        a_seq = '{4'd1, 4'd2, 4'd3};
        b_seq = '{4'd9, 4'd10, 4'd11};
        want  = '{4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11};
        do_reset();
        for (int cyc = 0; cyc < 30; cyc++) begin
            bus.a_valid = (ia < 3);
            bus.a_addr  = a_seq[(ia < 3) ? ia : 0];
            bus.a_data  = 16'(ia);
            bus.b_valid = (ib < 3);
            bus.b_addr  = b_seq[(ib < 3) ? ib : 0];
            bus.b_data  = 16'(ib);
            #1;
            acc_a = bus.a_valid && bus.a_ready;
            acc_b = bus.b_valid && bus.b_ready;
            tick();
            if (acc_a) ia++;
            if (acc_b) ib++;
            if (bus.w_wr === 1'b1) begin
                got_addr.push_back(bus.w_addr);
                got_cyc.push_back(cyc);
            end
        end
        quiet_inputs();
        checks++; if (got_addr.size() != 6) begin errors++; $display("FAIL rr_count got %0d want 6", got_addr.size()); end
        for (int k = 0; k < 6 && k < got_addr.size(); k++) begin
            checks++; if (got_addr[k] !== want[k]) begin errors++; $display("FAIL rr_order[%0d] got %0d want %0d", k, got_addr[k], want[k]); end
            checks++; if (got_cyc[k] != got_cyc[0] + k) begin errors++; $display("FAIL rr_consecutive[%0d] got cycle %0d want %0d", k, got_cyc[k], got_cyc[0] + k); end
        end
    endtask

    // Random traffic against a model: each queue holds accepted, not yet retired writes.
    task automatic run_traffic(input int pa, input int pb, input int ncyc, output int b_stalls);
        ent_t          qa [$];
        ent_t          qb [$];
        logic [NE-1:0] exp_busy;
        ent_t          got;
        bit            acc_a;
        bit            acc_b;
        b_stalls = 0;
        do_reset();
        for (int cyc = 0; cyc < ncyc + 20; cyc++) begin
            if (cyc < ncyc) begin
                bus.a_valid = ($urandom_range(0, 99) < pa);
                bus.a_addr  = AW'($urandom_range(0, NE - 1));
                bus.a_data  = {1'b0, 15'($urandom)};
                bus.b_valid = ($urandom_range(0, 99) < pb);
                bus.b_addr  = AW'($urandom_range(0, NE - 1));
                bus.b_data  = {1'b1, 15'($urandom)};
            end else begin
                quiet_inputs();
            end
            #1;
            checks++; if (bus.a_ready !== (qa.size() < 2)) begin errors++; $display("FAIL traffic_a_ready cyc %0d got %b want %0d", cyc, bus.a_ready, qa.size() < 2); end
            checks++; if (bus.b_ready !== (qb.size() < 2)) begin errors++; $display("FAIL traffic_b_ready cyc %0d got %b want %0d", cyc, bus.b_ready, qb.size() < 2); end
            acc_a = bus.a_valid && bus.a_ready;
            acc_b = bus.b_valid && bus.b_ready;
            if (bus.b_valid && !bus.b_ready) b_stalls++;
            if (acc_a && !(ZERO_EN && bus.a_addr == '0)) qa.push_back({bus.a_addr, bus.a_data});
            if (acc_b && !(ZERO_EN && bus.b_addr == '0)) qb.push_back({bus.b_addr, bus.b_data});
            tick();
            exp_busy = '0;
            foreach (qa[i]) exp_busy[qa[i][DW +: AW]] = 1'b1;
            foreach (qb[i]) exp_busy[qb[i][DW +: AW]] = 1'b1;
            checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL traffic_busy cyc %0d got %h want %h", cyc, bus.busy, exp_busy); end
            checks++; if (bus.idle !== (qa.size() == 0 && qb.size() == 0)) begin errors++; $display("FAIL traffic_idle cyc %0d got %b", cyc, bus.idle); end
            if (bus.w_wr === 1'b1) begin
                got = {bus.w_addr, bus.w_data};
                checks++;
                if (bus.w_data[DW-1] == 1'b0) begin
                    if (qa.size() == 0) begin errors++; $display("FAIL traffic_a_spurious got %h want none", got); end
                    else begin
                        if (got !== qa[0]) begin errors++; $display("FAIL traffic_a_order got %h want %h", got, qa[0]); end
                        void'(qa.pop_front());
                    end
                end else begin
                    if (qb.size() == 0) begin errors++; $display("FAIL traffic_b_spurious got %h want none", got); end
                    else begin
                        if (got !== qb[0]) begin errors++; $display("FAIL traffic_b_order got %h want %h", got, qb[0]); end
                        void'(qb.pop_front());
                    end
                end
            end
        end
        checks++; if (qa.size() != 0 || qb.size() != 0) begin errors++; $display("FAIL traffic_drain got %0d/%0d pending want 0/0", qa.size(), qb.size()); end
    endtask

    task automatic test_stall();
        int stalls;
        run_traffic(100, 100, 24, stalls);
        checks++; if (stalls == 0) begin errors++; $display("FAIL stall_b_ready got %0d stalls want >0", stalls); end
    endtask

    task automatic test_random();
        int stalls;
        run_traffic(60, 55, 400, stalls);
        run_traffic(30, 90, 200, stalls);
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.a_valid = 1'b1; bus.a_addr = 4'd6; bus.a_data = 16'h0A0A;
        bus.b_valid = 1'b1; bus.b_addr = 4'd7; bus.b_data = 16'h0B0B;
        repeat (5) tick();
        checks++; if (bus.w_wr !== 1'b1) begin errors++; $display("FAIL midop_pre_w_wr got %b want 1", bus.w_wr); end
        rst = 1'b1;
        #1;
        checks++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin errors++; $display("FAIL midop_ready_in_rst got %b want 00", {bus.a_ready, bus.b_ready}); end
        tick();
        checks++; if (bus.w_wr !== 1'b0) begin errors++; $display("FAIL midop_w_wr got %b want 0", bus.w_wr); end
        checks++; if (bus.busy !== 16'h0000) begin errors++; $display("FAIL midop_busy got %h want 0", bus.busy); end
        checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL midop_idle got %b want 1", bus.idle); end
        checks++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin errors++; $display("FAIL midop_ready got %b want 00", {bus.a_ready, bus.b_ready}); end
        rst = 1'b0;
        quiet_inputs();
        #1;
        checks++; if ({bus.a_ready, bus.b_ready} !== 2'b11) begin errors++; $display("FAIL midop_release_ready got %b want 11", {bus.a_ready, bus.b_ready}); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if ({bus.w_wr, bus.idle} !== 2'b01) begin errors++; $display("FAIL midop_no_pulse[%0d] got wr=%b idle=%b want 0/1", k, bus.w_wr, bus.idle); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.a_valid = 1'b1; bus.a_addr = 4'd5; bus.a_data = 16'h0001;
        tick();
        checks++; if (bus.w_wr !== 1'b0 || bus.busy[5] !== 1'b1) begin errors++; $display("FAIL b2b_c1 got wr=%b busy5=%b want 0/1", bus.w_wr, bus.busy[5]); end
        bus.a_data = 16'h0002;
        #1;
        checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", bus.a_ready); end
        tick();
        bus.a_valid = 1'b0;
        checks++; if ({bus.w_wr, bus.w_addr, bus.w_data} !== {1'b1, 4'd5, 16'h0001}) begin
            errors++; $display("FAIL b2b_first got wr=%b addr=%h data=%h want 1/5/0001", bus.w_wr, bus.w_addr, bus.w_data); end
        checks++; if (bus.busy[5] !== 1'b1) begin errors++; $display("FAIL b2b_busy_first got %b want 1", bus.busy[5]); end
        tick();
        checks++; if ({bus.w_wr, bus.w_addr, bus.w_data} !== {1'b1, 4'd5, 16'h0002}) begin
            errors++; $display("FAIL b2b_second got wr=%b addr=%h data=%h want 1/5/0002", bus.w_wr, bus.w_addr, bus.w_data); end
        checks++; if (bus.busy[5] !== 1'b1) begin errors++; $display("FAIL b2b_busy_second got %b want 1", bus.busy[5]); end
        tick();
        checks++; if (bus.w_wr !== 1'b0 || bus.busy !== 16'h0000 || bus.w_data !== 16'h0002) begin
            errors++; $display("FAIL b2b_after got wr=%b busy=%h data=%h want 0/0000/0002", bus.w_wr, bus.busy, bus.w_data); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        bus.a_valid = 1'b1; bus.a_addr = 4'd0; bus.a_data = 16'hFFFF;
        #1;
        checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", bus.a_ready); end
        tick();
        bus.a_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (bus.w_wr !== (!ZERO_EN && k == 2)) begin errors++; $display("FAIL zero_w_wr[c+%0d] got %b want %0d", k, bus.w_wr, !ZERO_EN && k == 2); end
            checks++;
            if (bus.busy[0] !== (!ZERO_EN && k <= 2)) begin errors++; $display("FAIL zero_busy0[c+%0d] got %b want %0d", k, bus.busy[0], !ZERO_EN && k <= 2); end
            if (!ZERO_EN && k == 2) begin
                checks++;
                if ({bus.w_addr, bus.w_data} !== {4'd0, 16'hFFFF}) begin errors++; $display("FAIL zero_write got addr=%h data=%h want 0/FFFF", bus.w_addr, bus.w_data); end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        quiet_inputs();
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_reset_midop();
        test_back_to_back();
        test_zero_reg();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
